// File: rtl/imem_loader.sv
// UART bootloader: receives a framed program image on uart_rx and writes
// little-endian 32-bit words into instruction memory, holding the core in reset while loading.
module imem_loader #(
  parameter int CLK_HZ      = 27_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk_core,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  // ---------------- receiver ----------------
  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_frame_err;
  logic             w_rx_fall, w_rx_tick;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_tick = (r_rx_state == RX_START) ? (r_rx_cnt == CNT_W'(HALF - 1))
                                         : (r_rx_cnt == CNT_W'(DIV - 1));
    unique case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_next;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
      else                                    r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      if (w_rx_tick) begin
        unique case (r_rx_state)
          RX_START: r_bit_idx <= '0;
          RX_DATA: begin
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          RX_STOP: begin
            r_byte_valid <= r_rx_s2;
            r_frame_err  <= ~r_rx_s2;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t            r_state, w_next;
  logic [7:0]        r_len_lo, r_csum;
  logic [15:0]       r_words_left;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_addr, r_waddr;
  logic [31:0]       r_wdata;
  logic              r_we, r_hold, r_ok, r_err;
  logic [TO_W-1:0]   r_idle_cnt;
  logic [15:0]       w_len;
  logic              w_in_frame, w_timeout, w_busy;

  assign w_len      = {r_shift, r_len_lo};
  assign w_in_frame = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout  = (r_idle_cnt >= TO_W'(TIMEOUT_CYC));

  always_comb begin
    w_next = r_state;
    w_busy = w_in_frame;
    unique case (r_state)
      S_IDLE: if (r_byte_valid && r_shift == SYNC_BYTE) w_next = S_LEN0;
      S_DONE, S_ERR: w_next = S_IDLE;
      default: begin
        // Inside a frame: framing error beats a byte, a byte beats a timeout.
        if (r_frame_err) w_next = S_ERR;
        else if (r_byte_valid) begin
          unique case (r_state)
            S_LEN0: w_next = S_LEN1;
            S_LEN1: begin
              if ({1'b0, w_len} > MAX_WORDS) w_next = S_ERR;
              else if (w_len == 16'd0)       w_next = S_CSUM;
              else                           w_next = S_DATA;
            end
            S_DATA: if (r_byte_idx == 2'd3 && r_words_left == 16'd1) w_next = S_CSUM;
            S_CSUM: w_next = (r_shift == r_csum) ? S_DONE : S_ERR;
            default: w_next = S_ERR;
          endcase
        end else if (w_timeout) w_next = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len_lo     <= '0;
      r_csum       <= '0;
      r_words_left <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_hold       <= 1'b0;
      r_ok         <= 1'b0;
      r_err        <= 1'b0;
      r_idle_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;

      if (w_in_frame && !r_byte_valid) r_idle_cnt <= r_idle_cnt + TO_W'(1);
      else                             r_idle_cnt <= '0;

      if (r_state == S_IDLE && w_next == S_LEN0) begin
        r_hold     <= 1'b1;
        r_ok       <= 1'b0;
        r_err      <= 1'b0;
        r_addr     <= '0;
        r_csum     <= '0;
        r_byte_idx <= '0;
      end

      if (r_byte_valid) begin
        if (r_state == S_LEN0) r_len_lo     <= r_shift;
        if (r_state == S_LEN1) r_words_left <= w_len;
        if (r_state == S_DATA) begin
          r_csum     <= r_csum ^ r_shift;
          r_byte_idx <= r_byte_idx + 2'd1;
          r_word     <= {r_shift, r_word[23:8]};
          if (r_byte_idx == 2'd3) begin
            r_we         <= 1'b1;
            r_waddr      <= r_addr;
            r_wdata      <= {r_shift, r_word};
            r_addr       <= r_addr + ADDR_W'(1);
            r_words_left <= r_words_left - 16'd1;
          end
        end
      end

      if (w_next == S_DONE) r_ok <= 1'b1;
      if (w_next == S_ERR)  r_err <= 1'b1;
      // Hold is released one cycle into DONE; after ERR it stays asserted.
      if (r_state == S_DONE) r_hold <= 1'b0;
    end
  end

  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign busy       = w_busy;
  assign load_ok    = r_ok;
  assign load_err   = r_err;

endmodule
